// File: rtl/datapath_param.sv
// rtl/datapath_param.sv - parametrised accumulator datapath with shift-add multiplier
// Holds PC, MAR, MDR, IR and ACC, a four-operation ALU with Z/N/C flags, and an
// iterative multiplier that owns ACC from start until the product is written.
module datapath_param #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 8,
  parameter int OPC_W  = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              loadPC,
  input  logic              muxPC,
  input  logic              loadMAR,
  input  logic              muxMAR,
  input  logic              loadMDR,
  input  logic              loadIR,
  input  logic              loadACC,
  input  logic              muxACC,
  input  logic [1:0]        opALU,
  input  logic              mulStart,
  output logic              busy,
  output logic              mulDone,
  output logic              zflag,
  output logic              nflag,
  output logic              cflag,
  output logic [OPC_W-1:0]  opcode,
  output logic [ADDR_W-1:0] MemAddr,
  output logic [DATA_W-1:0] MemD,
  input  logic [DATA_W-1:0] MemQ
);

  localparam int HALF  = DATA_W / 2;
  localparam int CNT_W = (HALF > 1) ? $clog2(HALF) : 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } mul_state_t;

  mul_state_t r_state;
  mul_state_t w_state_next;

  logic [ADDR_W-1:0] r_pc;
  logic [ADDR_W-1:0] r_mar;
  logic [DATA_W-1:0] r_mdr;
  logic [DATA_W-1:0] r_ir;
  logic [DATA_W-1:0] r_acc;
  logic              r_z;
  logic              r_n;
  logic              r_c;

  logic [DATA_W-1:0] r_mcand;
  logic [HALF-1:0]   r_mplier;
  logic [DATA_W-1:0] r_prod;
  logic [CNT_W-1:0]  r_cnt;

  logic [ADDR_W-1:0] w_ir_addr;
  logic [ADDR_W-1:0] w_pc_inc;
  logic [DATA_W:0]   w_add;
  logic [DATA_W:0]   w_sub;
  logic [DATA_W-1:0] w_alu_res;
  logic              w_alu_c;
  logic              w_mul_accept;
  logic              w_mul_last;
  logic              w_acc_load;
  logic              w_acc_we;
  logic [DATA_W-1:0] w_acc_next;
  logic              w_c_next;
  logic [DATA_W-1:0] w_prod_next;

  assign w_ir_addr = r_ir[DATA_W-1 -: ADDR_W];
  assign w_pc_inc  = r_pc + ADDR_W'(1);
  assign w_add     = {1'b0, r_acc} + {1'b0, r_mdr};
  assign w_sub     = {1'b0, r_acc} - {1'b0, r_mdr};

  // A multiply may start from IDLE or from the DONE cycle; a same-edge loadACC wins.
  assign w_mul_accept = mulStart && !loadACC && (r_state != S_RUN);
  assign w_mul_last   = (r_state == S_RUN) && (r_cnt == CNT_W'(HALF - 1));
  assign w_acc_load   = loadACC && (r_state != S_RUN);
  assign w_acc_we     = w_mul_last || w_acc_load;
  assign w_prod_next  = r_prod + (r_mplier[0] ? r_mcand : '0);

  assign busy    = (r_state == S_RUN);
  assign mulDone = (r_state == S_DONE);
  assign zflag   = r_z;
  assign nflag   = r_n;
  assign cflag   = r_c;
  assign opcode  = r_ir[OPC_W-1:0];
  assign MemAddr = r_mar;
  assign MemD    = r_acc;

  // ALU result and carry/borrow for the selected operation
  always_comb begin
    w_alu_res = '0;
    w_alu_c   = 1'b0;
    case (opALU)
      2'b00: begin
        w_alu_res = w_add[DATA_W-1:0];
        w_alu_c   = w_add[DATA_W];
      end
      2'b01: begin
        w_alu_res = w_sub[DATA_W-1:0];
        w_alu_c   = w_sub[DATA_W];
      end
      2'b10: w_alu_res = r_acc & r_mdr;
      default: w_alu_res = r_acc | r_mdr;
    endcase
  end

  // Value and carry written to ACC/flags; the product write takes priority
  always_comb begin
    w_acc_next = r_acc;
    w_c_next   = 1'b0;
    if (w_mul_last) begin
      w_acc_next = w_prod_next;
    end else if (w_acc_load) begin
      if (muxACC) begin
        w_acc_next = r_mdr;
      end else begin
        w_acc_next = w_alu_res;
        w_c_next   = w_alu_c;
      end
    end
  end

  // Multiplier state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Multiplier next-state logic
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE: if (w_mul_accept) w_state_next = S_RUN;
      S_RUN:  if (w_mul_last) w_state_next = S_DONE;
      S_DONE: w_state_next = w_mul_accept ? S_RUN : S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
  end

  // Multiplier operand latch and one shift-add step per RUN cycle
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_mcand  <= '0;
      r_mplier <= '0;
      r_prod   <= '0;
      r_cnt    <= '0;
    end else if (w_mul_accept) begin
      r_mcand  <= {{(DATA_W - HALF){1'b0}}, r_acc[HALF-1:0]};
      r_mplier <= r_mdr[HALF-1:0];
      r_prod   <= '0;
      r_cnt    <= '0;
    end else if (r_state == S_RUN) begin
      r_prod   <= w_prod_next;
      r_mcand  <= r_mcand << 1;
      r_mplier <= r_mplier >> 1;
      r_cnt    <= r_cnt + CNT_W'(1);
    end
  end

  // Architectural registers; every source is the pre-edge value
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pc  <= '0;
      r_mar <= '0;
      r_mdr <= '0;
      r_ir  <= '0;
      r_acc <= '0;
      r_z   <= 1'b0;
      r_n   <= 1'b0;
      r_c   <= 1'b0;
    end else begin
      if (loadPC)  r_pc  <= muxPC ? w_ir_addr : w_pc_inc;
      if (loadMAR) r_mar <= muxMAR ? r_pc : w_ir_addr;
      if (loadMDR) r_mdr <= MemQ;
      if (loadIR)  r_ir  <= r_mdr;
      if (w_acc_we) begin
        r_acc <= w_acc_next;
        r_z   <= (w_acc_next == '0);
        r_n   <= w_acc_next[DATA_W-1];
        r_c   <= w_c_next;
      end
    end
  end

endmodule

// File: tb/tb_datapath_param.sv
// tb/tb_datapath_param.sv - scoreboard bench for datapath_param
module tb_datapath_param;

  logic        clk = 1'b0;
  logic        rst;
  logic        loadPC, muxPC, loadMAR, muxMAR, loadMDR, loadIR, loadACC, muxACC;
  logic [1:0]  opALU;
  logic        mulStart;
  logic        busy, mulDone, zflag, nflag, cflag;
  logic [7:0]  opcode;
  logic [7:0]  MemAddr;
  logic [15:0] MemD;
  logic [15:0] MemQ;

  datapath_param #(.DATA_W(16), .ADDR_W(8), .OPC_W(8)) dut (
    .clk(clk), .rst(rst),
    .loadPC(loadPC), .muxPC(muxPC), .loadMAR(loadMAR), .muxMAR(muxMAR),
    .loadMDR(loadMDR), .loadIR(loadIR), .loadACC(loadACC), .muxACC(muxACC),
    .opALU(opALU), .mulStart(mulStart), .busy(busy), .mulDone(mulDone),
    .zflag(zflag), .nflag(nflag), .cflag(cflag), .opcode(opcode),
    .MemAddr(MemAddr), .MemD(MemD), .MemQ(MemQ)
  );

  always #5 clk = ~clk;

  localparam int SEL_ACC = 0, SEL_Z = 1, SEL_N = 2, SEL_C = 3;
  localparam int SEL_BUSY = 4, SEL_DONE = 5, SEL_ADDR = 6, SEL_OPC = 7;

  typedef struct {
    string       name;
    int          sel;
    logic [31:0] exp;
  } snap_t;

  typedef struct {
    string       name;
    logic [15:0] acc;
    logic [2:0]  znc;
    int          lat;
  } prod_t;

  snap_t snap_q[$];
  prod_t prod_q[$];
  event  chk_ev;
  int    n_checks = 0;
  int    n_errors = 0;
  int    busy_run = 0;

  function automatic logic [31:0] get_out(int sel);
    case (sel)
      SEL_ACC:  return {16'h0, MemD};
      SEL_Z:    return {31'h0, zflag};
      SEL_N:    return {31'h0, nflag};
      SEL_C:    return {31'h0, cflag};
      SEL_BUSY: return {31'h0, busy};
      SEL_DONE: return {31'h0, mulDone};
      SEL_ADDR: return {24'h0, MemAddr};
      default:  return {24'h0, opcode};
    endcase
  endfunction

  task automatic cmp(string nm, logic [31:0] act, logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  // Snapshot monitor: compares queued expectations at the falling edge or on request
  always @(negedge clk or chk_ev) begin
    while (snap_q.size() > 0) begin
      snap_t s;
      s = snap_q.pop_front();
      cmp(s.name, get_out(s.sel), s.exp);
    end
  end

  // Product monitor: counts busy cycles and checks each mulDone against the queue
  always @(negedge clk) begin
    if (rst) begin
      busy_run = 0;
    end else begin
      if (busy) busy_run++;
      if (mulDone) begin
        if (prod_q.size() == 0) begin
          cmp("unexpected_mulDone", 32'd1, 32'd0);
        end else begin
          prod_t p;
          p = prod_q.pop_front();
          cmp({p.name, "_acc"}, {16'h0, MemD}, {16'h0, p.acc});
          cmp({p.name, "_znc"}, {29'h0, zflag, nflag, cflag}, {29'h0, p.znc});
          cmp({p.name, "_busy_cycles"}, busy_run, p.lat);
        end
        busy_run = 0;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(string nm, int sel, logic [31:0] v);
    snap_t s;
    s.name = nm;
    s.sel  = sel;
    s.exp  = v;
    snap_q.push_back(s);
  endtask

  task automatic chk_flags(string nm, logic z, logic n, logic c);
    chk({nm, "_z"}, SEL_Z, {31'h0, z});
    chk({nm, "_n"}, SEL_N, {31'h0, n});
    chk({nm, "_c"}, SEL_C, {31'h0, c});
  endtask

  task automatic push_prod(string nm, logic [15:0] acc, logic [2:0] znc);
    prod_t p;
    p.name = nm;
    p.acc  = acc;
    p.znc  = znc;
    p.lat  = 8;
    prod_q.push_back(p);
  endtask

  task automatic load_mdr(logic [15:0] v);
    MemQ = v; loadMDR = 1'b1;
    tick();
    loadMDR = 1'b0;
  endtask

  task automatic load_acc(logic [15:0] v);
    load_mdr(v);
    muxACC = 1'b1; loadACC = 1'b1;
    tick();
    loadACC = 1'b0; muxACC = 1'b0;
  endtask

  task automatic alu_op(logic [1:0] op);
    opALU = op; muxACC = 1'b0; loadACC = 1'b1;
    tick();
    loadACC = 1'b0;
  endtask

  task automatic wait_done();
    int i;
    i = 0;
    while (!mulDone && i < 30) begin
      tick();
      i++;
    end
    if (!mulDone) begin
      n_checks++;
      n_errors++;
      $display("FAIL mul_timeout: mulDone not seen within %0d cycles", i);
    end
  endtask

  initial begin
    rst = 1'b1;
    loadPC = 0; muxPC = 0; loadMAR = 0; muxMAR = 0; loadMDR = 0; loadIR = 0;
    loadACC = 0; muxACC = 0; opALU = 2'b00; mulStart = 0; MemQ = 16'h0;
    tick(); tick();
    chk("rst_acc", SEL_ACC, 0);
    chk_flags("rst", 0, 0, 0);
    chk("rst_busy", SEL_BUSY, 0);
    chk("rst_done", SEL_DONE, 0);
    chk("rst_addr", SEL_ADDR, 0);
    chk("rst_opc", SEL_OPC, 0);
    tick();
    rst = 1'b0;
    tick();

    // ADD with carry out
    load_acc(16'hFFFF);
    chk("mdrload_acc", SEL_ACC, 16'hFFFF);
    chk_flags("mdrload", 0, 1, 0);
    load_mdr(16'h0001);
    alu_op(2'b00);
    chk("add_acc", SEL_ACC, 16'h0000);
    chk_flags("add", 1, 0, 1);

    // SUB with borrow
    load_acc(16'h0003);
    load_mdr(16'h0005);
    alu_op(2'b01);
    chk("sub_acc", SEL_ACC, 16'hFFFE);
    chk_flags("sub", 0, 1, 1);

    // AND / OR
    load_acc(16'hF0F0);
    load_mdr(16'h3C3C);
    alu_op(2'b10);
    chk("and_acc", SEL_ACC, 16'h3030);
    chk_flags("and", 0, 0, 0);
    alu_op(2'b11);
    chk("or_acc", SEL_ACC, 16'h3C3C);
    chk_flags("or", 0, 0, 0);

    // Jump via IR address field, then MAR <= PC
    load_mdr(16'h4211);
    loadIR = 1; tick(); loadIR = 0;
    chk("jmp_opc", SEL_OPC, 8'h11);
    loadPC = 1; muxPC = 1; tick(); loadPC = 0; muxPC = 0;
    loadMAR = 1; muxMAR = 1; tick(); loadMAR = 0; muxMAR = 0;
    chk("jmp_pc", SEL_ADDR, 8'h42);

    // MAR from the IR address field
    load_mdr(16'h7700);
    loadIR = 1; tick(); loadIR = 0;
    loadMAR = 1; muxMAR = 0; tick(); loadMAR = 0;
    chk("mar_ir", SEL_ADDR, 8'h77);

    // PC wrap 0xFF -> 0x00
    load_mdr(16'hFF00);
    loadIR = 1; tick(); loadIR = 0;
    loadPC = 1; muxPC = 1; tick(); muxPC = 0;
    tick(); loadPC = 0;
    loadMAR = 1; muxMAR = 1; tick(); loadMAR = 0; muxMAR = 0;
    chk("pc_wrap", SEL_ADDR, 8'h00);

    // Coincident loadMDR + loadIR: IR takes the old MDR
    load_mdr(16'hAAAA);
    MemQ = 16'h5555; loadMDR = 1; loadIR = 1; tick(); loadMDR = 0; loadIR = 0;
    chk("coinc_opc", SEL_OPC, 8'hAA);
    muxACC = 1; loadACC = 1; tick(); loadACC = 0; muxACC = 0;
    chk("coinc_mdr", SEL_ACC, 16'h5555);

    // 5 x 7 with cflag set beforehand; product clears it
    load_acc(16'hFFFF);
    load_mdr(16'h0006);
    alu_op(2'b00);
    chk("pre_mul_acc", SEL_ACC, 16'h0005);
    chk_flags("pre_mul", 0, 0, 1);
    load_mdr(16'h0007);
    mulStart = 1; push_prod("mul_5x7", 16'h0023, 3'b000);
    tick(); mulStart = 0;
    chk("mul_busy_first", SEL_BUSY, 1);
    wait_done();
    tick();
    chk("mul_done_pulse", SEL_DONE, 0);

    // 0xFF x 0xFF with an ignored loadACC and an honoured loadMDR during RUN
    load_acc(16'h00FF);
    load_mdr(16'h00FF);
    mulStart = 1; push_prod("mul_ffxff", 16'hFE01, 3'b010);
    tick(); mulStart = 0;
    tick();
    MemQ = 16'h0BEE; loadMDR = 1; muxACC = 1; loadACC = 1;
    tick();
    loadMDR = 0; loadACC = 0; muxACC = 0;
    wait_done();
    tick();
    muxACC = 1; loadACC = 1; tick(); loadACC = 0; muxACC = 0;
    chk("run_mdr_load", SEL_ACC, 16'h0BEE);

    // Only low halves are multiplied; back-to-back start in the mulDone cycle
    load_acc(16'h1203);
    load_mdr(16'h4504);
    mulStart = 1; push_prod("mul_low", 16'h000C, 3'b000);
    tick(); mulStart = 0;
    wait_done();
    mulStart = 1; push_prod("mul_b2b", 16'h0030, 3'b000);
    tick(); mulStart = 0;
    chk("b2b_busy", SEL_BUSY, 1);
    wait_done();
    tick();

    // loadACC wins over a same-edge mulStart
    load_mdr(16'h1234);
    muxACC = 1; loadACC = 1; mulStart = 1;
    tick();
    muxACC = 0; loadACC = 0; mulStart = 0;
    chk("coll_acc", SEL_ACC, 16'h1234);
    chk("coll_busy", SEL_BUSY, 0);
    tick();
    chk("coll_busy2", SEL_BUSY, 0);
    tick();

    // Reset in RUN cycle 4 clears outputs without a clock edge
    load_acc(16'h8003);
    load_mdr(16'h0005);
    mulStart = 1; push_prod("mul_aborted", 16'h000F, 3'b000);
    tick(); mulStart = 0;
    tick(); tick(); tick();
    #2;
    rst = 1'b1;
    prod_q.delete();
    #1;
    chk("rstmid_acc", SEL_ACC, 0);
    chk_flags("rstmid", 0, 0, 0);
    chk("rstmid_busy", SEL_BUSY, 0);
    chk("rstmid_done", SEL_DONE, 0);
    -> chk_ev;
    tick(); tick();
    rst = 1'b0;
    repeat (15) tick();
    chk("post_rst_busy", SEL_BUSY, 0);
    tick();

    cmp("prod_queue_drained", prod_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
